// File: rtl/csm_arbiter.sv
// csm_arbiter: two-port shared single-port memory controller with round-robin access and hold/release locking.
// Define CSM_ARB_TIMEOUT_EN to enable the lock watchdog (LOCK_TIMEOUT cycles).
module csm_arbiter #(
  parameter int DATABITS = 8,
  parameter int ERRBITS = 2,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATABITS-1:0] A_in_AD,
  input  logic                A_rw,
  input  logic                A_enable,
  input  logic                A_hold,
  input  logic                A_release,
  output logic                A_ack,
  output logic [ERRBITS-1:0]  A_err,
  output logic [DATABITS-1:0] A_out_data,
  input  logic [DATABITS-1:0] B_in_AD,
  input  logic                B_rw,
  input  logic                B_enable,
  input  logic                B_hold,
  input  logic                B_release,
  output logic                B_ack,
  output logic [ERRBITS-1:0]  B_err,
  output logic [DATABITS-1:0] B_out_data,
  output logic [DATABITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATABITS-1:0] mem_rdata
);
  typedef enum logic [2:0] {M_IDLE, M_RD1, M_RD2, M_WR, M_WR2} mstate_t;
  mstate_t state, state_n;
  logic [1:0] en, rw_in, hold, rel, rise, acc;
  logic [1:0] prev_en, wpend, valid, busy, hc, own, ack, rw;
  logic [1:0] wpend_n, valid_n, busy_n, hc_n, own_n, ack_n, rw_n;
  logic [DATABITS-1:0] ad [2];
  logic [DATABITS-1:0] addr [2], wdata [2], rdata [2];
  logic [DATABITS-1:0] addr_n [2], wdata_n [2], rdata_n [2];
  logic [ERRBITS-1:0] err [2], err_n [2];
  logic [DATABITS-1:0] mem_addr_n, mem_wdata_n;
  logic gsel, gsel_n, g, prio_b, prio_b_n, conflict, loser, acq;
`ifdef CSM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_n;
`else
  logic unused_lt;
  assign unused_lt = ^LOCK_TIMEOUT;
`endif
  assign en = {B_enable, A_enable};
  assign rw_in = {B_rw, A_rw};
  assign hold = {B_hold, A_hold};
  assign rel = {B_release, A_release};
  assign ad[0] = A_in_AD;
  assign ad[1] = B_in_AD;
  assign A_ack = ack[0];
  assign B_ack = ack[1];
  assign A_err = err[0];
  assign B_err = err[1];
  assign A_out_data = rdata[0];
  assign B_out_data = rdata[1];
  assign mem_we = state == M_WR;
  assign mem_re = state == M_RD1;
  always_comb begin
    state_n = state;
    gsel_n = gsel;
    prio_b_n = prio_b;
    wpend_n = wpend;
    valid_n = valid;
    busy_n = busy;
    hc_n = '0;
    own_n = own;
    rw_n = rw;
    addr_n = addr;
    wdata_n = wdata;
    rdata_n = rdata;
    err_n = err;
    mem_addr_n = mem_addr;
    mem_wdata_n = mem_wdata;
    rise = en & ~prev_en;
    acc = rise & ack;
    conflict = &(acc & hold & ~rel);
    loser = ~prio_b;
    acq = 1'b0;
    g = ~(valid[0] & (~valid[1] | ~prio_b));
    case (state)
      M_IDLE: if (|valid) begin
        state_n = rw[g] ? M_WR : M_RD1;
        gsel_n = g;
        valid_n[g] = 1'b0;
        busy_n[g] = 1'b1;
        prio_b_n = ~prio_b;
        mem_addr_n = addr[g];
        mem_wdata_n = wdata[g];
      end
      M_RD1: state_n = M_RD2;
      M_RD2: begin
        state_n = M_IDLE;
        rdata_n[gsel] = mem_rdata;
        busy_n[gsel] = 1'b0;
      end
      // a write frees its port as soon as the strobe is done; M_WR2 only spaces the memory
      M_WR: begin
        state_n = M_WR2;
        busy_n[gsel] = 1'b0;
      end
      default: state_n = M_IDLE;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (wpend[i]) begin
        wdata_n[i] = ad[i];
        wpend_n[i] = 1'b0;
        valid_n[i] = 1'b1;
      end
      if (acc[i] & hold[i] & rel[i]) err_n[i] = ERRBITS'(3);
      else if (acc[i] & hold[i]) begin
        if (own[1-i] | (conflict & (loser == 1'(i)))) err_n[i] = ERRBITS'(3);
        else begin
          own_n[i] = 1'b1;
          err_n[i] = '0;
          hc_n[i] = 1'b1;
          acq = 1'b1;
        end
      end else if (acc[i] & rel[i]) begin
        own_n[i] = 1'b0;
        hc_n[i] = own[i];
        err_n[i] = own[i] ? '0 : ERRBITS'(2);
      end else if (acc[i]) begin
        err_n[i] = '0;
        rw_n[i] = rw_in[i];
        addr_n[i] = ad[i];
        wpend_n[i] = rw_in[i];
        valid_n[i] = ~rw_in[i];
      end else if (rise[i] & own[1-i]) err_n[i] = ERRBITS'(1);
    end
`ifdef CSM_ARB_TIMEOUT_EN
    cnt_n = acq ? '0 : cnt;
    if (!acq && |own) begin
      if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
        for (int i = 0; i < 2; i++) if (own_n[i]) err_n[i] = ERRBITS'(2);
        own_n = '0;
        cnt_n = '0;
      end else cnt_n = cnt + CW'(1);
    end
`endif
    for (int i = 0; i < 2; i++) ack_n[i] = ~(wpend_n[i] | valid_n[i] | busy_n[i] | hc_n[i] | own_n[1-i]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= M_IDLE;
      gsel <= 1'b0;
      prio_b <= 1'b0;
      prev_en <= '1;
      wpend <= '0;
      valid <= '0;
      busy <= '0;
      hc <= '0;
      own <= '0;
      ack <= '1;
      rw <= '0;
      addr <= '{default: '0};
      wdata <= '{default: '0};
      rdata <= '{default: '0};
      err <= '{default: '0};
      mem_addr <= '0;
      mem_wdata <= '0;
`ifdef CSM_ARB_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      state <= state_n;
      gsel <= gsel_n;
      prio_b <= prio_b_n;
      prev_en <= en;
      wpend <= wpend_n;
      valid <= valid_n;
      busy <= busy_n;
      hc <= hc_n;
      own <= own_n;
      ack <= ack_n;
      rw <= rw_n;
      addr <= addr_n;
      wdata <= wdata_n;
      rdata <= rdata_n;
      err <= err_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
`ifdef CSM_ARB_TIMEOUT_EN
      cnt <= cnt_n;
`endif
    end
  end
endmodule

// File: tb/tb_csm_arbiter.sv
// tb_csm_arbiter: directed vector table plus hand sequences for contention, reset, lock races and watchdog.
module tb_csm_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] a_ad, b_ad, a_out, b_out, mem_addr, mem_wdata, mem_rdata;
  logic a_rw, a_en, a_h, a_r, b_rw, b_en, b_h, b_r, a_ack, b_ack, mem_we, mem_re;
  logic [1:0] a_err, b_err;
  logic [7:0] mem [256];
  int errors = 0, checks = 0;
  typedef struct {
    logic rst;
    logic [3:0] a;
    logic [7:0] aad;
    logic [3:0] b;
    logic [7:0] bad;
    logic [1:0] ack;
    logic [1:0] aerr, berr;
    logic [7:0] aout, bout;
    logic we, re;
  } vec_t;
  vec_t v [25];
  always #5 clk = ~clk;
  csm_arbiter #(.DATABITS(8), .ERRBITS(2), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .A_in_AD(a_ad), .A_rw(a_rw), .A_enable(a_en), .A_hold(a_h), .A_release(a_r),
    .A_ack(a_ack), .A_err(a_err), .A_out_data(a_out),
    .B_in_AD(b_ad), .B_rw(b_rw), .B_enable(b_en), .B_hold(b_h), .B_release(b_r),
    .B_ack(b_ack), .B_err(b_err), .B_out_data(b_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end
  task automatic drive(input logic r, input logic [3:0] a, input logic [7:0] aad,
                       input logic [3:0] b, input logic [7:0] bad);
    @(negedge clk);
    reset = r;
    {a_en, a_rw, a_h, a_r} = a;
    a_ad = aad;
    {b_en, b_rw, b_h, b_r} = b;
    b_ad = bad;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int s, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", n, s, act, exp);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'b0, 8'h00, 4'b0, 8'h00);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem_rdata = 8'h00;
    // a={en,rw,hold,rel}; ack={A_ack,B_ack}
    v[0]  = '{1'b1, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    v[1]  = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    v[2]  = '{1'b0, 4'b1100, 8'h10, 4'b0000, 8'h00, 2'b01, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    v[3]  = '{1'b0, 4'b1100, 8'h5A, 4'b0000, 8'h00, 2'b01, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    v[4]  = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b01, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0};
    v[5]  = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    v[6]  = '{1'b0, 4'b1000, 8'h10, 4'b0000, 8'h00, 2'b01, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    v[7]  = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b01, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1};
    v[8]  = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b01, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    v[9]  = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b11, 2'd0, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[10] = '{1'b0, 4'b1010, 8'h00, 4'b0000, 8'h00, 2'b00, 2'd0, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[11] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b10, 2'd0, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[12] = '{1'b0, 4'b0000, 8'h00, 4'b1000, 8'h44, 2'b10, 2'd0, 2'd1, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[13] = '{1'b0, 4'b1100, 8'h33, 4'b0000, 8'h00, 2'b00, 2'd0, 2'd1, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[14] = '{1'b0, 4'b1100, 8'h77, 4'b0000, 8'h00, 2'b00, 2'd0, 2'd1, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[15] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b00, 2'd0, 2'd1, 8'h5A, 8'h00, 1'b1, 1'b0};
    v[16] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b10, 2'd0, 2'd1, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[17] = '{1'b0, 4'b1001, 8'h00, 4'b0000, 8'h00, 2'b01, 2'd0, 2'd1, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[18] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b11, 2'd0, 2'd1, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[19] = '{1'b0, 4'b0000, 8'h00, 4'b1001, 8'h00, 2'b11, 2'd0, 2'd2, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[20] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b11, 2'd0, 2'd2, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[21] = '{1'b0, 4'b0000, 8'h00, 4'b1000, 8'h33, 2'b10, 2'd0, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[22] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b10, 2'd0, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b1};
    v[23] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b10, 2'd0, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b0};
    v[24] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'b11, 2'd0, 2'd0, 8'h5A, 8'h77, 1'b0, 1'b0};
    reset = 1'b1;
    {a_en, a_rw, a_h, a_r, b_en, b_rw, b_h, b_r} = '0;
    a_ad = 8'h00;
    b_ad = 8'h00;
    for (int s = 0; s < 25; s++) begin
      drive(v[s].rst, v[s].a, v[s].aad, v[s].b, v[s].bad);
      chk("ack", s, {6'b0, a_ack, b_ack}, {6'b0, v[s].ack});
      chk("A_err", s, {6'b0, a_err}, {6'b0, v[s].aerr});
      chk("B_err", s, {6'b0, b_err}, {6'b0, v[s].berr});
      chk("A_out_data", s, a_out, v[s].aout);
      chk("B_out_data", s, b_out, v[s].bout);
      chk("mem_we", s, {7'b0, mem_we}, {7'b0, v[s].we});
      chk("mem_re", s, {7'b0, mem_re}, {7'b0, v[s].re});
    end
    // simultaneous reads: A first, B one full read later
    drive(1'b1, 4'b0, 8'h00, 4'b0, 8'h00);
    idle(1);
    drive(1'b0, 4'b1000, 8'h20, 4'b1000, 8'h21);
    idle(2);
    chk("cont A_ack k+2", 102, {7'b0, a_ack}, 8'h00);
    idle(1);
    chk("cont A_ack k+3", 103, {7'b0, a_ack}, 8'h01);
    chk("cont A_out_data", 103, a_out, 8'h85);
    chk("cont B_ack k+3", 103, {7'b0, b_ack}, 8'h00);
    idle(2);
    chk("cont B_ack k+5", 105, {7'b0, b_ack}, 8'h00);
    idle(1);
    chk("cont B_ack k+6", 106, {7'b0, b_ack}, 8'h01);
    chk("cont B_out_data", 106, b_out, 8'h84);
    // reset lands during M_RD2 with enable held high
    drive(1'b1, 4'b0, 8'h00, 4'b0, 8'h00);
    chk("rst A_out_data", 200, a_out, 8'h00);
    idle(1);
    drive(1'b0, 4'b1000, 8'h40, 4'b0, 8'h00);
    drive(1'b0, 4'b1000, 8'h40, 4'b0, 8'h00);
    chk("rd mem_re k+1", 201, {7'b0, mem_re}, 8'h01);
    drive(1'b0, 4'b1000, 8'h40, 4'b0, 8'h00);
    drive(1'b1, 4'b1000, 8'h40, 4'b0, 8'h00);
    chk("mid A_out_data", 203, a_out, 8'h00);
    chk("mid A_ack", 203, {7'b0, a_ack}, 8'h01);
    chk("mid mem_addr", 203, mem_addr, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1000, 8'h40, 4'b0, 8'h00);
      chk("post mem_re", 204 + i, {7'b0, mem_re}, 8'h00);
      chk("post A_ack", 204 + i, {7'b0, a_ack}, 8'h01);
    end
    chk("post A_out_data", 208, a_out, 8'h00);
    // both hold on one edge: A wins after reset, B gets illegal
    drive(1'b1, 4'b0, 8'h00, 4'b0, 8'h00);
    idle(1);
    drive(1'b0, 4'b1010, 8'h00, 4'b1010, 8'h00);
    chk("dual A_err", 300, {6'b0, a_err}, 8'h00);
    chk("dual B_err", 300, {6'b0, b_err}, 8'h03);
    chk("dual ack", 300, {6'b0, a_ack, b_ack}, 8'h00);
    idle(1);
    chk("dual ack k+1", 301, {6'b0, a_ack, b_ack}, 8'h02);
    drive(1'b0, 4'b1001, 8'h00, 4'b0, 8'h00);
    chk("dual rel B_ack", 302, {7'b0, b_ack}, 8'h01);
    chk("dual B_err held", 302, {6'b0, b_err}, 8'h03);
`ifdef CSM_ARB_TIMEOUT_EN
    drive(1'b1, 4'b0, 8'h00, 4'b0, 8'h00);
    idle(1);
    drive(1'b0, 4'b1010, 8'h00, 4'b0, 8'h00);
    idle(7);
    chk("wd B_ack k+7", 407, {7'b0, b_ack}, 8'h00);
    chk("wd A_err k+7", 407, {6'b0, a_err}, 8'h00);
    idle(1);
    chk("wd B_ack k+8", 408, {7'b0, b_ack}, 8'h01);
    chk("wd A_err k+8", 408, {6'b0, a_err}, 8'h02);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
